// File: rtl/alu64_serial.sv
// Purpose: bit-serial NOR/XOR/ADD/SUB ALU; SLICE bits of both operands are processed per cycle, carry chained across slices.
// Latency: result valid WIDTH/SLICE cycles after the accept edge; one request in flight at a time.
// Backpressure: result held stable in DONE until out_ready; in_ready low from accept until the result is taken.
module alu64_serial #(
    parameter int WIDTH = 64,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    // A width that does not split into whole slices cannot be sequenced.
    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("alu64_serial: WIDTH must be an integer multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_nx;
    logic [1:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             valid_q;
    logic [SLICE-1:0] sl_res;
    logic             sl_c;
    logic             ai;
    logic             bi;
    logic             c;

    // One slice of the ripple: low SLICE bits of the shifting operands, carry enters from the previous slice.
    always_comb begin
        sl_res = '0;
        c      = carry;
        ai     = 1'b0;
        bi     = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            ai = a_q[i];
            bi = b_q[i] ^ (op_q == 2'b11);
            case (op_q)
                2'b00:   sl_res[i] = ~(ai | bi);
                2'b01:   sl_res[i] = ai ^ bi;
                default: sl_res[i] = ai ^ bi ^ c;
            endcase
            c = (ai & bi) | (ai & c) | (bi & c);
        end
        sl_c   = c;
        // New result bits enter at the MSB end; after NSL slices the LSB slice has reached bit 0.
        res_nx = WIDTH'({sl_res, res_q} >> SLICE);
    end

    // Next-state logic; illegal encodings and out-of-range counts fall back to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = RUN;
            RUN: begin
                if (int'(cnt) >= NSL)  state_nx = IDLE;
                else if (cnt == LAST)  state_nx = DONE;
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, plus a registered copy of "next is DONE" so out_valid comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            valid_q <= (state_nx == DONE);
        end
    end

    // Operand capture on accept, then shift operands/result one slice per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            op_q  <= 2'b00;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            carry <= cin;
            cnt   <= '0;
            res_q <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> SLICE;
            b_q   <= b_q >> SLICE;
            carry <= sl_c;
            res_q <= res_nx;
            cnt   <= cnt + 1'b1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN) || (state == DONE);
    assign out_valid = valid_q;
    assign s         = valid_q ? res_q : '0;
    assign cout      = valid_q & op_q[1] & carry;

endmodule

// File: tb/tb_alu64_serial.sv
// Directed bench for alu64_serial at SLICE=1 and SLICE=8.
// Expected results come from a 65-bit arithmetic model pushed to a scoreboard queue at accept time.
// Covers reset values, latency, all four ops, DONE backpressure and reset abort mid-RUN.
module tb_alu64_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid8 = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        out_ready = 1'b0;
    logic        out_ready8 = 1'b0;

    logic        in_ready, out_valid, cout, busy;
    logic [63:0] s;
    logic        in_ready8, out_valid8, cout8, busy8;
    logic [63:0] s8;

    int total = 0;
    int bad   = 0;
    logic [64:0] sb[$];

    always #5 clk = ~clk;

    alu64_serial #(.WIDTH(64), .SLICE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .busy(busy)
    );

    alu64_serial #(.WIDTH(64), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid8),
        .out_ready(out_ready8), .s(s8), .cout(cout8), .busy(busy8)
    );

    function automatic logic [64:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic mc, input logic [1:0] mo);
        logic [64:0] r;
        case (mo)
            2'b00:   r = {1'b0, ~(ma | mb)};
            2'b01:   r = {1'b0, ma ^ mb};
            2'b10:   r = {1'b0, ma} + {1'b0, mb} + 65'(mc);
            default: r = {1'b0, ma} + {1'b0, ~mb} + 65'(mc);
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input bit u8, input logic [63:0] ta, input logic [63:0] tb,
                            input logic tc, input logic [1:0] to);
        int n = 0;
        while (!(u8 ? in_ready8 : in_ready) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_accept", 65'(u8 ? in_ready8 : in_ready), 65'd1);
        a = ta; b = tb; cin = tc; op = to;
        if (u8) in_valid8 = 1'b1; else in_valid = 1'b1;
        sb.push_back(model(ta, tb, tc, to));
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid8 = 1'b0;
    endtask

    task automatic wait_result(input bit u8, input int exp_lat, output logic [64:0] got_exp);
        int n = 0;
        while (!(u8 ? out_valid8 : out_valid) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 65'(n), 65'(exp_lat));
        got_exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check("result", u8 ? {cout8, s8} : {cout, s}, got_exp);
        check("busy_in_done", 65'(u8 ? busy8 : busy), 65'd1);
        check("in_ready_in_done", 65'(u8 ? in_ready8 : in_ready), 65'd0);
    endtask

    task automatic handshake(input bit u8);
        if (u8) out_ready8 = 1'b1; else out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; out_ready8 = 1'b0;
        check("idle_after_handshake",
              u8 ? {out_valid8, in_ready8, busy8, cout8, s8} : {out_valid, in_ready, busy, cout, s},
              {1'b0, 1'b1, 1'b0, 1'b0, 64'd0});
    endtask

    task automatic full_op(input bit u8, input int lat, input logic [63:0] ta,
                           input logic [63:0] tb, input logic tc, input logic [1:0] to);
        logic [64:0] e;
        start_op(u8, ta, tb, tc, to);
        wait_result(u8, lat, e);
        handshake(u8);
    endtask

    initial begin
        logic [64:0] e;
        int pulses;

        // Reset values while rst_n is held low.
        #2;
        check("reset_outputs", {in_ready, out_valid, busy, cout, s}, {1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD overflow, exact 64-cycle latency.
        full_op(1'b0, 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10);
        // SUB both directions.
        full_op(1'b0, 64, 64'd5, 64'd3, 1'b1, 2'b11);
        full_op(1'b0, 64, 64'd3, 64'd5, 1'b1, 2'b11);
        // Logic ops.
        full_op(1'b0, 64, 64'd0, 64'd0, 1'b0, 2'b00);
        full_op(1'b0, 64, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 2'b01);
        // A few random mixed-op requests.
        for (int i = 0; i < 4; i++)
            full_op(1'b0, 64, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                    2'(i));

        // Backpressure: hold DONE for 10 cycles while inputs wiggle.
        start_op(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 2'b10);
        wait_result(1'b0, 64, e);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            a = {$urandom, $urandom};
            @(posedge clk); #1;
            check("hold_in_done", {out_valid, in_ready, cout, s}, {1'b1, 1'b0, e});
        end
        in_valid = 1'b0;
        handshake(1'b0);

        // Reset 30 cycles into RUN aborts the operation.
        start_op(1'b0, 64'hAAAA_0000_5555_FFFF, 64'h1111_2222_3333_4444, 1'b0, 2'b10);
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid_run", {in_ready, out_valid, busy, cout, s}, {1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
        void'(sb.pop_back());
        pulses = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("no_pulse_after_abort", 65'(pulses), 65'd0);
        full_op(1'b0, 64, 64'd7, 64'd8, 1'b0, 2'b10);

        // SLICE=8 instance: carry ripples across byte slices, 8-cycle latency.
        full_op(1'b1, 8, 64'h00FF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10);
        full_op(1'b1, 8, 64'd3, 64'd5, 1'b1, 2'b11);

        check("scoreboard_empty", 65'(sb.size()), 65'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
